// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS sweep controller and its accumulator.
package dds_pkg;

    localparam int DDS_PHASE_W = 10;
    localparam int DDS_DWELL_W = 16;
    localparam int MIDSCALE    = 100;
    localparam int PHASE_MAX   = 1023;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_TONE  = 2'd2,
        ST_DONE  = 2'd3
    } dds_state_e;

    typedef struct packed {
        logic [DDS_PHASE_W-1:0] start;
        logic [DDS_PHASE_W-1:0] stop;
        logic [DDS_PHASE_W-1:0] step;
        logic [DDS_DWELL_W-1:0] dwell;
        logic                   continuous;
    } dds_cfg_t;

    // Move cur one step toward stop, landing exactly on stop instead of passing it.
    function automatic logic [DDS_PHASE_W-1:0] ftw_toward_stop(
        input logic [DDS_PHASE_W-1:0] cur,
        input logic [DDS_PHASE_W-1:0] stop,
        input logic [DDS_PHASE_W-1:0] step,
        input logic                   down
    );
        logic [DDS_PHASE_W-1:0] gap;
        logic [DDS_PHASE_W-1:0] res;
        if (down) begin
            gap = cur - stop;
            if (gap <= step) begin
                res = stop;
            end else begin
                res = cur - step;
            end
        end else begin
            gap = stop - cur;
            if (gap <= step) begin
                res = stop;
            end else begin
                res = cur + step;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dds_phase_accumulator.sv
// Phase accumulator: adds the tuning word on each enabled tick, flags carry-out.
module dds_phase_accumulator
    import dds_pkg::*;
#(
    parameter int PHASE_W = DDS_PHASE_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear,
    input  logic [PHASE_W-1:0] ftw,
    output logic [PHASE_W-1:0] phase,
    output logic               phase_wrap
);

    logic [PHASE_W-1:0] phase_r;
    logic               wrap_r;
    logic [PHASE_W:0]   sum_s;

    assign sum_s      = {1'b0, phase_r} + {1'b0, ftw};
    assign phase      = phase_r;
    assign phase_wrap = wrap_r;

    // Phase register: clear wins over accumulate; wrap pulses only on an actual carry.
    always_ff @(posedge clock) begin
        if (!reset) begin
            phase_r <= '0;
            wrap_r  <= 1'b0;
        end else if (clear) begin
            phase_r <= '0;
            wrap_r  <= 1'b0;
        end else if (enable) begin
            phase_r <= sum_s[PHASE_W-1:0];
            wrap_r  <= sum_s[PHASE_W];
        end else begin
            phase_r <= phase_r;
            wrap_r  <= 1'b0;
        end
    end

endmodule

// File: rtl/dds_sweep_controller.sv
// Sweep sequencer: accepts one configuration, then steps the FTW through a
// linear sweep (single or continuous) or holds a fixed tone until done/abort.
module dds_sweep_controller
    import dds_pkg::*;
#(
    parameter int PHASE_W = DDS_PHASE_W,
    parameter int DWELL_W = DDS_DWELL_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_ftw_start,
    input  logic [PHASE_W-1:0] cfg_ftw_stop,
    input  logic [PHASE_W-1:0] cfg_ftw_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_continuous,
    input  logic               abort,
    output logic [PHASE_W-1:0] phase,
    output logic [PHASE_W-1:0] ftw_cur,
    output logic               sweep_active,
    output logic               sweep_done,
    output logic               phase_wrap
);

    dds_state_e         state_r,     state_nxt_s;
    dds_cfg_t           cfg_r,       cfg_nxt_s;
    logic               down_r,      down_nxt_s;
    logic [PHASE_W-1:0] ftw_r,       ftw_nxt_s;
    logic [DWELL_W-1:0] dwell_cnt_r, dwell_cnt_nxt_s;
    logic [DWELL_W-1:0] dwell_last_s;
    logic               active_r;
    logic               done_r,      done_nxt_s;
    logic               acc_en_s;
    logic               acc_clr_s;
    logic               dwell_end_s;

    assign cfg_ready    = (state_r == ST_IDLE);
    assign ftw_cur      = ftw_r;
    assign sweep_active = active_r;
    assign sweep_done   = done_r;

    // Last dwell count of a step; a programmed dwell of zero behaves as one tick.
    always_comb begin
        if (cfg_r.dwell == {DWELL_W{1'b0}}) begin
            dwell_last_s = {DWELL_W{1'b0}};
        end else begin
            dwell_last_s = cfg_r.dwell - {{(DWELL_W-1){1'b0}}, 1'b1};
        end
    end

    assign dwell_end_s = (dwell_cnt_r == dwell_last_s);

    // Next-state and datapath-control decode; abort always beats dwell expiry.
    always_comb begin
        state_nxt_s     = state_r;
        cfg_nxt_s       = cfg_r;
        down_nxt_s      = down_r;
        ftw_nxt_s       = ftw_r;
        dwell_cnt_nxt_s = dwell_cnt_r;
        done_nxt_s      = 1'b0;
        acc_en_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                dwell_cnt_nxt_s = {DWELL_W{1'b0}};
                if (cfg_valid) begin
                    cfg_nxt_s.start      = cfg_ftw_start;
                    cfg_nxt_s.stop       = cfg_ftw_stop;
                    cfg_nxt_s.step       = cfg_ftw_step;
                    cfg_nxt_s.dwell      = cfg_dwell;
                    cfg_nxt_s.continuous = cfg_continuous;
                    down_nxt_s           = (cfg_ftw_stop < cfg_ftw_start);
                    ftw_nxt_s            = cfg_ftw_start;
                    if (cfg_ftw_step == {PHASE_W{1'b0}}) begin
                        state_nxt_s = ST_TONE;
                    end else begin
                        state_nxt_s = ST_SWEEP;
                    end
                end else begin
                    ftw_nxt_s = {PHASE_W{1'b0}};
                end
            end
            ST_TONE: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                    ftw_nxt_s   = {PHASE_W{1'b0}};
                end else begin
                    acc_en_s = enable;
                end
            end
            ST_SWEEP: begin
                if (abort) begin
                    state_nxt_s     = ST_IDLE;
                    ftw_nxt_s       = {PHASE_W{1'b0}};
                    dwell_cnt_nxt_s = {DWELL_W{1'b0}};
                end else if (enable) begin
                    if (dwell_end_s) begin
                        dwell_cnt_nxt_s = {DWELL_W{1'b0}};
                        if (ftw_r != cfg_r.stop) begin
                            ftw_nxt_s = ftw_toward_stop(ftw_r, cfg_r.stop, cfg_r.step, down_r);
                            acc_en_s  = 1'b1;
                        end else if (cfg_r.continuous) begin
                            ftw_nxt_s = cfg_r.start;
                            acc_en_s  = 1'b1;
                        end else begin
                            state_nxt_s = ST_DONE;
                            ftw_nxt_s   = {PHASE_W{1'b0}};
                            done_nxt_s  = 1'b1;
                        end
                    end else begin
                        dwell_cnt_nxt_s = dwell_cnt_r + {{(DWELL_W-1){1'b0}}, 1'b1};
                        acc_en_s        = 1'b1;
                    end
                end else begin
                    dwell_cnt_nxt_s = dwell_cnt_r;
                end
            end
            ST_DONE: begin
                state_nxt_s     = ST_IDLE;
                ftw_nxt_s       = {PHASE_W{1'b0}};
                dwell_cnt_nxt_s = {DWELL_W{1'b0}};
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                ftw_nxt_s       = {PHASE_W{1'b0}};
                dwell_cnt_nxt_s = {DWELL_W{1'b0}};
            end
        endcase
    end

    // Phase is forced to zero whenever the next state is not running.
    assign acc_clr_s = (state_nxt_s != ST_SWEEP) && (state_nxt_s != ST_TONE);

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Configuration, FTW, dwell counter and status output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cfg_r       <= '0;
            down_r      <= 1'b0;
            ftw_r       <= {PHASE_W{1'b0}};
            dwell_cnt_r <= {DWELL_W{1'b0}};
            active_r    <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            cfg_r       <= cfg_nxt_s;
            down_r      <= down_nxt_s;
            ftw_r       <= ftw_nxt_s;
            dwell_cnt_r <= dwell_cnt_nxt_s;
            active_r    <= (state_nxt_s == ST_SWEEP) || (state_nxt_s == ST_TONE);
            done_r      <= done_nxt_s;
        end
    end

    dds_phase_accumulator #(
        .PHASE_W (PHASE_W)
    ) u_acc (
        .clock      (clock),
        .reset      (reset),
        .enable     (acc_en_s),
        .clear      (acc_clr_s),
        .ftw        (ftw_r),
        .phase      (phase),
        .phase_wrap (phase_wrap)
    );

endmodule

// File: doc/dds_sweep_controller.md
Name: dds_sweep_controller

Overview:
- Sequences the DDS datapath: owns the 10-bit phase accumulator, drives the phase bus into the phase-to-amplitude converter, and schedules the frequency tuning word (FTW).
- Accepts one configuration per run via a valid/ready handshake, then runs a stepped linear frequency sweep (single or continuous) or a fixed tone until done or aborted.
- Sits between the control/register interface and the sine lookup.

Parameters:
- PHASE_W, 10, phase accumulator and FTW width (matches the converter's phase input).
- DWELL_W, 16, width of the dwell counter (enable ticks per frequency step).

Ports:
- clock  in  1  system clock (1 MHz).
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
- enable  in  1  sample-tick strobe. Accumulator and dwell counter advance only when it is high.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  controller can accept a configuration.
- cfg_ftw_start  in  PHASE_W  first FTW of the sweep.
- cfg_ftw_stop  in  PHASE_W  last FTW of the sweep.
- cfg_ftw_step  in  PHASE_W  FTW increment magnitude. 0 selects tone mode.
- cfg_dwell  in  DWELL_W  enable ticks per step. 0 is treated as 1.
- cfg_continuous  in  1  1 = restart the sweep from start after reaching stop; 0 = single sweep.
- abort  in  1  stop the current run.
- phase  out  PHASE_W  accumulator value, to the converter.
- ftw_cur  out  PHASE_W  FTW currently applied.
- sweep_active  out  1  high in SWEEP or TONE.
- sweep_done  out  1  one-cycle pulse at the end of a single sweep.
- phase_wrap  out  1  one-cycle pulse when the accumulator carries out.

Behaviour:
- Reset (reset==0 at a clock edge):
  - State IDLE.
  - phase=0, ftw_cur=0, dwell_cnt=0, cfg_ready=1.
  - sweep_active=0, sweep_done=0, phase_wrap=0.
  - A reset mid-run discards the run with no sweep_done.
- States:
  - IDLE: cfg_ready=1, phase held at 0 (converter outputs midscale).
  - Handshake: cfg_valid&&cfg_ready at edge N latches all cfg_* and sets ftw_cur=start.
  - At N+1: step==0 → TONE, else → SWEEP. dir=down when stop<start.
  - cfg_ready=0 in every state except IDLE. cfg_valid outside IDLE is ignored and nothing is captured.
  - TONE: ftw_cur is constant at start until abort.
  - SWEEP: dwell_cnt increments per enable tick. When dwell_cnt==max(dwell,1)-1 and enable is high, dwell_cnt clears and one of the following happens:
    - ftw_cur!=stop: ftw_cur moves one step toward stop, clamped so it never passes stop (no modular wrap of the FTW).
    - ftw_cur==stop and cfg_continuous=1: ftw_cur=start, stay in SWEEP.
    - ftw_cur==stop and cfg_continuous=0: go to DONE.
  - start==stop with step!=0: the run is one dwell at start, then the end-of-sweep rule applies.
  - DONE: one cycle. sweep_done=1, phase←0, ftw_cur←0, then IDLE.
- Accumulator:
  - In SWEEP and TONE with enable=1: phase ← (phase+ftw_cur) mod 2^PHASE_W.
  - phase_wrap=1 in the same cycle the sum carries out, else 0.
  - The new ftw_cur takes effect on the next tick (registered, one tick latency).
- enable low freezes phase, dwell_cnt and ftw_cur. State transitions that depend only on handshake or abort still occur.
- abort:
  - In SWEEP or TONE, abort at an edge → IDLE next cycle with phase=0 and ftw_cur=0, no sweep_done.
  - Abort beats a simultaneous final dwell expiry (no sweep_done).
  - In IDLE, abort has no effect; a simultaneous cfg_valid is still accepted.
- All outputs are registered. There are no combinational paths from inputs to outputs except cfg_ready, which is a decode of the state register.

Decomposition:
- Shared package dds_pkg:
  - state encoding (IDLE, SWEEP, TONE, DONE).
  - PHASE_W and DWELL_W defaults.
  - MIDSCALE=100 and PHASE_MAX=1023 constants.
  - a cfg struct/typedef grouping start, stop, step, dwell, continuous.
- One natural sub-module, dds_phase_accumulator: phase register, ftw input, enable, clear input, carry → phase_wrap.
- The FSM and the step/clamp logic stay in dds_sweep_controller.

Test Plan:
- Reset: hold reset=0 for 3 cycles with cfg_valid=1 → phase=0, ftw_cur=0, cfg_ready=1, sweep_active=0, nothing captured.
- Up sweep: start=10, stop=40, step=10, dwell=4, single mode, enable=1 → ftw_cur sequence 10,20,30,40, each held 4 ticks. sweep_done pulses exactly once. phase returns to 0, then IDLE with cfg_ready=1.
- Clamp and down sweep: start=100, stop=75, step=10, dwell=1 → ftw_cur 100,90,80,75. Then continuous=1 with the same config → 75 is followed by 100, with no sweep_done.
- Tone and wrap: step=0, start=256, enable every cycle → phase 0,256,512,768,0. phase_wrap is high exactly on the 768→0 step. The run holds until abort, after which phase=0 and ftw_cur=0.
- Abort at last dwell: single sweep, assert abort on the final-step expiry edge → IDLE, no sweep_done. cfg_valid offered mid-run is not captured (cfg_ready=0), and the run continues unchanged.
- enable gating: enable toggling 1/0 with dwell=2 → each FTW held for 2 enable-high ticks. phase is unchanged in enable-low cycles.
